// File: rtl/assign_seq_pkg.sv
// Shared types and constants for the assignment-sequence checker.
package assign_seq_pkg;

  typedef enum logic [1:0] {IDLE, SEED, CHECK, DONE} state_t;

  localparam logic [1:0] STEP_ADD   = 2'd0;
  localparam logic [1:0] STEP_SUB   = 2'd1;
  localparam logic [1:0] STEP_INC10 = 2'd2;
  localparam logic [1:0] STEP_INCC  = 2'd3;

  localparam int SUB_K = 3;
  localparam int ADD_K = 10;
  localparam int INC_K = 1;

  // Seed beat plus four beats per loop iteration.
  function automatic int beats_per_run(input int rep);
    return 1 + 4 * rep;
  endfunction

endpackage

// File: rtl/assign_seq_predict.sv
// Combinational next-snapshot predictor: applies one step of the recurrence.
module assign_seq_predict
  import assign_seq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]   step,
  input  logic [W-1:0] exp_a,
  input  logic [W-1:0] exp_b,
  input  logic [W-1:0] exp_c,
  input  logic [W-1:0] exp_d,
  output logic [W-1:0] nxt_a,
  output logic [W-1:0] nxt_b,
  output logic [W-1:0] nxt_c,
  output logic [W-1:0] nxt_d
);

  // Only the field named by the step changes; arithmetic wraps mod 2^W.
  always_comb begin
    nxt_a = exp_a;
    nxt_b = exp_b;
    nxt_c = exp_c;
    nxt_d = exp_d;
    case (step)
      STEP_ADD:   nxt_a = exp_b + exp_c;
      STEP_SUB:   nxt_d = exp_a - W'(SUB_K);
      STEP_INC10: nxt_b = exp_d + W'(ADD_K);
      STEP_INCC:  nxt_c = exp_c + W'(INC_K);
      default: ;
    endcase
  end

endmodule

// File: rtl/assign_seq_checker.sv
// Stream checker for the a=b+c; d=a-3; b=d+10; c=c+1 recurrence.
// Optional idle watchdog enabled by defining ASSIGN_CHK_TIMEOUT_EN.
module assign_seq_checker
  import assign_seq_pkg::*;
#(
  parameter int W       = 32,
  parameter int REPEAT  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_c,
  input  logic [W-1:0] in_d,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         err,
  output logic [7:0]   err_beat,
  output logic [3:0]   err_field,
  output logic         timeout
);

  if (beats_per_run(REPEAT) > 255) begin : g_repeat_chk
    $error("assign_seq_checker: REPEAT too large for 8-bit beat counter");
  end

  localparam logic [7:0] LAST_BEAT = 8'(beats_per_run(REPEAT) - 1);

  state_t       state, state_nxt;
  logic [7:0]   beat;
  logic [1:0]   step;
  logic [W-1:0] exp_a, exp_b, exp_c, exp_d;
  logic [W-1:0] prd_a, prd_b, prd_c, prd_d;
  logic [3:0]   mismatch;
  logic         accept;
  logic         last_beat;
  logic         to_fire;

  assign busy      = (state == SEED) || (state == CHECK);
  assign in_ready  = busy;
  assign done      = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat == LAST_BEAT);

  assign_seq_predict #(.W(W)) u_predict (
    .step  (step),
    .exp_a (exp_a),
    .exp_b (exp_b),
    .exp_c (exp_c),
    .exp_d (exp_d),
    .nxt_a (prd_a),
    .nxt_b (prd_b),
    .nxt_c (prd_c),
    .nxt_d (prd_d)
  );

  assign mismatch = {in_d != prd_d, in_c != prd_c, in_b != prd_b, in_a != prd_a};

`ifdef ASSIGN_CHK_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] idle_cnt;
  logic          timeout_q;

  // An accept in the same cycle as expiry wins over the watchdog.
  assign to_fire = busy && !accept && (idle_cnt == CW'(TIMEOUT - 1));
  assign timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!busy || accept) idle_cnt <= '0;
      else                 idle_cnt <= idle_cnt + CW'(1);
      if (state == IDLE && start) timeout_q <= 1'b0;
      else if (to_fire)           timeout_q <= 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEED;
      SEED: begin
        if (accept)       state_nxt = CHECK;
        else if (to_fire) state_nxt = DONE;
      end
      CHECK: begin
        if (accept && ((mismatch != 4'd0) || last_beat)) state_nxt = DONE;
        else if (!accept && to_fire)                     state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat      <= '0;
      step      <= '0;
      exp_a     <= '0;
      exp_b     <= '0;
      exp_c     <= '0;
      exp_d     <= '0;
      pass      <= 1'b0;
      err       <= 1'b0;
      err_beat  <= '0;
      err_field <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          beat      <= '0;
          step      <= '0;
          pass      <= 1'b0;
          err       <= 1'b0;
          err_beat  <= '0;
          err_field <= '0;
        end
        SEED: begin
          if (accept) begin
            exp_a <= in_a;
            exp_b <= in_b;
            exp_c <= in_c;
            exp_d <= in_d;
            beat  <= 8'd1;
            step  <= STEP_ADD;
          end else if (to_fire) begin
            err       <= 1'b1;
            err_beat  <= beat;
            err_field <= '0;
          end
        end
        CHECK: begin
          if (accept) begin
            if (mismatch != 4'd0) begin
              err       <= 1'b1;
              err_beat  <= beat;
              err_field <= mismatch;
            end else begin
              // Accepted snapshot equals the prediction, so it becomes the new base.
              exp_a <= in_a;
              exp_b <= in_b;
              exp_c <= in_c;
              exp_d <= in_d;
              beat  <= beat + 8'd1;
              step  <= step + 2'd1;
              if (last_beat) pass <= 1'b1;
            end
          end else if (to_fire) begin
            err       <= 1'b1;
            err_beat  <= beat;
            err_field <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_assign_seq_checker.sv
// Directed self-checking bench for assign_seq_checker (REPEAT=4, TIMEOUT=64).
module tb_assign_seq_checker;

  localparam int W = 32;
  localparam int REPEAT = 4;
  localparam int TIMEOUT = 64;
  localparam int NB = 1 + 4 * REPEAT;

  logic         clk = 1'b0;
  logic         rst, start, in_valid;
  logic         in_ready, busy, done, pass, err, timeout;
  logic [W-1:0] in_a, in_b, in_c, in_d;
  logic [7:0]   err_beat;
  logic [3:0]   err_field;

  int checks = 0;
  int passed = 0;

  logic [W-1:0] ga [NB];
  logic [W-1:0] gb [NB];
  logic [W-1:0] gc [NB];
  logic [W-1:0] gd [NB];

  always #5 clk = ~clk;

  assign_seq_checker #(.W(W), .REPEAT(REPEAT), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_d      (in_d),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err       (err),
    .err_beat  (err_beat),
    .err_field (err_field),
    .timeout   (timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Golden stream from the recurrence definition.
  task automatic gen(input logic [W-1:0] a, b, c, d);
    ga[0] = a; gb[0] = b; gc[0] = c; gd[0] = d;
    for (int k = 1; k < NB; k++) begin
      ga[k] = ga[k-1]; gb[k] = gb[k-1]; gc[k] = gc[k-1]; gd[k] = gd[k-1];
      case ((k - 1) % 4)
        0: ga[k] = gb[k-1] + gc[k-1];
        1: gd[k] = ga[k-1] - 32'd3;
        2: gb[k] = gd[k-1] + 32'd10;
        default: gc[k] = gc[k-1] + 32'd1;
      endcase
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
  endtask

  task automatic send(input logic [W-1:0] a, b, c, d, input int bubbles);
    bit ok;
    in_valid = 1'b0;
    for (int i = 0; i < bubbles; i++) tick();
    in_a = a; in_b = b; in_c = c; in_d = d;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) check("accept_wait", 0, 1);
  endtask

  task automatic send_beats(input int first, input int last, input bit bub);
    for (int k = first; k <= last; k++)
      send(ga[k], gb[k], gc[k], gd[k], bub ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic check_pass_end(input string tag);
    check({tag, "_done"}, done, 1);
    check({tag, "_pass"}, pass, 1);
    check({tag, "_err"}, err, 0);
    check({tag, "_ebeat"}, err_beat, 0);
    tick();
    check({tag, "_done_low"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_pass_hold"}, pass, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err, 0);
    check("rst_ebeat", err_beat, 0);
    check("rst_efield", err_field, 0);
    check("rst_timeout", timeout, 0);

    // Golden run
    gen(30, 20, 15, 5);
    do_start();
    check("seed_ready", in_ready, 1);
    send_beats(0, NB - 1, 0);
    check_pass_end("golden");

    // Corrupt d on beat 6 (expected 55)
    do_start();
    check("restart_clr_pass", pass, 0);
    send_beats(0, 5, 0);
    send(ga[6], gb[6], gc[6], 32'd54, 0);
    check("corr_done", done, 1);
    check("corr_err", err, 1);
    check("corr_pass", pass, 0);
    check("corr_ebeat", err_beat, 6);
    check("corr_efield", err_field, 4'b1000);
    check("corr_ready", in_ready, 0);
    in_valid = 1'b1;
    tick();
    check("corr_ready_after", in_ready, 0);
    check("corr_ebeat_hold", err_beat, 6);
    in_valid = 1'b0;

    // Signed wrap on beat 1
    gen(32'd0, 32'h7FFF_FFFF, 32'd1, 32'd0);
    check("wrap_model", ga[1], 32'h8000_0000);
    do_start();
    check("wrap_clr_err", err, 0);
    send_beats(0, NB - 1, 0);
    check_pass_end("wrap");

    // Golden stream with random bubbles
    gen(30, 20, 15, 5);
    do_start();
    send_beats(0, NB - 1, 1);
    check_pass_end("bubble");

    // start pulsed mid-run is ignored
    do_start();
    send_beats(0, 4, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("midstart_busy", busy, 1);
    send_beats(5, NB - 1, 0);
    check_pass_end("midstart");

    // Reset at beat 3, then a fresh passing run
    do_start();
    send_beats(0, 2, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_ready", in_ready, 0);
    check("mrst_pass", pass, 0);
    check("mrst_err", err, 0);
    tick();
    check("mrst_no_done", done, 0);
    do_start();
    send_beats(0, NB - 1, 0);
    check_pass_end("after_rst");

    // Stall after beat 2
    do_start();
    send_beats(0, 2, 0);
`ifdef ASSIGN_CHK_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (!done && n < 200) begin
        tick();
        n++;
      end
      check("to_cycles", n, TIMEOUT);
      check("to_err", err, 1);
      check("to_flag", timeout, 1);
      check("to_ebeat", err_beat, 3);
      check("to_efield", err_field, 0);
      tick();
    end
`else
    begin
      bit saw_done;
      saw_done = 1'b0;
      for (int i = 0; i < 80; i++) begin
        tick();
        if (done) saw_done = 1'b1;
      end
      check("stall_no_done", saw_done, 0);
      check("stall_busy", busy, 1);
      check("stall_timeout", timeout, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
